// File: rtl/scalar_mult_ctrl.sv
// scalar_mult_ctrl: left-to-right double-and-add sequencer computing Q = k*P.
// Drives an external point_addition instance. That adder is held in reset
// except while an operation is in flight.
module scalar_mult_ctrl #(
    parameter int unsigned N       = 230,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] k,
    input  logic [N-1:0] px,
    input  logic [N-1:0] py,
    output logic [N-1:0] qx,
    output logic [N-1:0] qy,
    output logic         q_inf,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic         pa_reset,
    output logic [N-1:0] pa_x1,
    output logic [N-1:0] pa_y1,
    output logic [N-1:0] pa_x2,
    output logic [N-1:0] pa_y2,
    input  logic [N-1:0] pa_x3,
    input  logic [N-1:0] pa_y3,
    input  logic         pa_result,
    input  logic         pa_infinity
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] TOP_IDX  = IW'(N - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BIT     = 3'd1,
        LAUNCH  = 3'd2,
        WAIT    = 3'd3,
        SETTLE  = 3'd4,
        CAPTURE = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t         r_state;
    state_t         w_next_state;

    logic [N-1:0]   r_k;
    logic [N-1:0]   r_px;
    logic [N-1:0]   r_py;
    logic [N-1:0]   r_qx;
    logic [N-1:0]   r_qy;
    logic           r_q_inf;
    logic [IW-1:0]  r_idx;
    logic           r_phase_add;
    logic [CW-1:0]  r_cnt;
    logic           r_inf_seen;
    logic           r_busy;
    logic           r_done;
    logic           r_error;
    logic           r_pa_reset;
    logic [N-1:0]   r_op_x1;
    logic [N-1:0]   r_op_y1;
    logic [N-1:0]   r_op_x2;
    logic [N-1:0]   r_op_y2;

    logic           w_bit;
    logic           w_last;
    logic           w_flag;
    logic           w_to_add;
    logic           w_advance;
    state_t         w_step_state;
    logic           w_busy_n;
    logic           w_done_n;
    logic           w_pa_reset_n;

    // Step decode: current scalar bit and where a finished step goes next
    always_comb begin
        w_bit        = r_k[N-1];
        w_last       = (r_idx == '0);
        w_flag       = pa_result | pa_infinity;
        w_to_add     = !r_phase_add && w_bit;
        w_step_state = (!w_to_add && w_last) ? DONE : BIT;
        w_advance    = ((r_state == BIT) && r_q_inf) || (r_state == CAPTURE);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = BIT;
            // Q at infinity makes both doubling and adding trivial: no launch
            BIT:     w_next_state = r_q_inf ? w_step_state : LAUNCH;
            LAUNCH:  w_next_state = WAIT;
            WAIT: begin
                if (w_flag) begin
                    w_next_state = SETTLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_next_state = DONE;
                end
            end
            SETTLE:  w_next_state = CAPTURE;
            CAPTURE: w_next_state = w_step_state;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered below
    always_comb begin
        w_busy_n     = 1'b0;
        w_done_n     = 1'b0;
        w_pa_reset_n = 1'b1;
        case (w_next_state)
            BIT, CAPTURE: w_busy_n = 1'b1;
            LAUNCH, WAIT, SETTLE: begin
                w_busy_n     = 1'b1;
                w_pa_reset_n = 1'b0;
            end
            DONE:    w_done_n = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, point accumulator, bit walker and WAIT timer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k         <= '0;
            r_px        <= '0;
            r_py        <= '0;
            r_qx        <= '0;
            r_qy        <= '0;
            r_q_inf     <= 1'b1;
            r_idx       <= '0;
            r_phase_add <= 1'b0;
            r_cnt       <= '0;
            r_inf_seen  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_pa_reset  <= 1'b1;
            r_op_x1     <= '0;
            r_op_y1     <= '0;
            r_op_x2     <= '0;
            r_op_y2     <= '0;
        end else begin
            r_busy     <= w_busy_n;
            r_done     <= w_done_n;
            r_pa_reset <= w_pa_reset_n;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_k         <= k;
                        r_px        <= px;
                        r_py        <= py;
                        r_qx        <= '0;
                        r_qy        <= '0;
                        r_q_inf     <= 1'b1;
                        r_idx       <= TOP_IDX;
                        r_phase_add <= 1'b0;
                        r_cnt       <= '0;
                        r_error     <= 1'b0;
                    end
                end
                BIT: begin
                    if (r_q_inf) begin
                        // Adding P to infinity yields P; doubling infinity is a no-op
                        if (r_phase_add) begin
                            r_qx    <= r_px;
                            r_qy    <= r_py;
                            r_q_inf <= 1'b0;
                        end
                    end else begin
                        r_op_x1    <= r_qx;
                        r_op_y1    <= r_qy;
                        r_op_x2    <= r_phase_add ? r_px : r_qx;
                        r_op_y2    <= r_phase_add ? r_py : r_qy;
                        r_cnt      <= '0;
                        r_inf_seen <= 1'b0;
                    end
                end
                WAIT: begin
                    if (w_flag) begin
                        r_inf_seen <= pa_infinity;
                    end else if (r_cnt == CNT_LAST) begin
                        r_error <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                SETTLE: begin
                    // Adder outputs are valid now, one cycle after its flag
                    if (r_inf_seen || pa_infinity) begin
                        r_q_inf <= 1'b1;
                    end else begin
                        r_qx    <= pa_x3;
                        r_qy    <= pa_y3;
                        r_q_inf <= 1'b0;
                    end
                end
                default: ;
            endcase

            // Step completion: DBL -> ADD on a set bit, otherwise move to the next bit
            if (w_advance) begin
                if (w_to_add) begin
                    r_phase_add <= 1'b1;
                end else if (!w_last) begin
                    r_idx       <= r_idx - IW'(1);
                    r_k         <= r_k << 1;
                    r_phase_add <= 1'b0;
                end
            end
        end
    end

    assign qx       = r_qx;
    assign qy       = r_qy;
    assign q_inf    = r_q_inf;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign pa_reset = r_pa_reset;
    assign pa_x1    = r_op_x1;
    assign pa_y1    = r_op_y1;
    assign pa_x2    = r_op_x2;
    assign pa_y2    = r_op_y2;

endmodule

// File: doc/scalar_mult_ctrl.md
SCALAR_MULT_CTRL -- requirements
Module: scalar_mult_ctrl

Interface
REQ-001 SHALL have parameter N, default 230, the coordinate and scalar width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 4096, the maximum cycles allowed per point_addition operation.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, single-cycle request to compute k*P; sampled only in IDLE.
REQ-006 SHALL have ports k, px and py, each input, N, holding the scalar and the affine base point; all three are captured on an accepted start.
REQ-007 SHALL have ports qx and qy, each output, N, holding the result point.
REQ-008 SHALL have port q_inf, output, 1; when high, the result is the point at infinity.
REQ-009 SHALL have port busy, output, 1, high from the cycle after an accepted start until done.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse when the result is valid.
REQ-011 SHALL have port error, output, 1, asserted together with done when the adder times out.
REQ-012 SHALL have port pa_reset, output, 1, which drives the reset input of the attached point_addition instance.
REQ-013 SHALL have ports pa_x1, pa_y1, pa_x2 and pa_y2, each output, N, carrying the adder operands.
REQ-014 SHALL have ports pa_x3 and pa_y3, each input, N, carrying the adder result.
REQ-015 SHALL have ports pa_result and pa_infinity, each input, 1, the adder completion flags.

Function
REQ-016 SHALL compute Q = k*P left-to-right from bit N-1 down to bit 0: Q = 2Q, then Q = Q + P if k[i] = 1; Q starts at infinity.
REQ-017 SHALL perform doubling by issuing pa_x1 = pa_x2 = Qx and pa_y1 = pa_y2 = Qy; the attached adder is complete and handles P == Q.
REQ-018 SHALL skip the adder when doubling while Q is infinity; Q stays infinity, with no launch.
REQ-019 SHALL skip the adder when adding while Q is infinity; Q takes the value P and q_inf clears, with no launch.
REQ-020 SHALL have FSM states IDLE, BIT, LAUNCH, WAIT, SETTLE, CAPTURE, DONE.
REQ-021 SHALL, in IDLE on start, load k into a shift register, load P, set Q to infinity and the bit index to N-1, set the phase to DBL, and go to BIT.
REQ-022 SHALL, in BIT, apply REQ-018/REQ-019 in one cycle when a skip applies; otherwise it drives the operands and goes to LAUNCH.
REQ-023 SHALL, in LAUNCH, hold pa_reset low with the operands stable; pa_reset is high in every state except LAUNCH, WAIT and SETTLE.
REQ-024 SHALL, in WAIT, count cycles; the first cycle in which pa_result or pa_infinity is high goes to SETTLE.
REQ-025 SHALL spend exactly one cycle in SETTLE, because the adder outputs become valid one cycle after its flag rises; it then goes to CAPTURE.
REQ-026 SHALL, in CAPTURE, latch Q = (pa_x3, pa_y3) with q_inf = 0, or set q_inf = 1 if pa_infinity was seen.
REQ-027 SHALL then advance the phase: DBL goes to ADD when k[i] = 1, otherwise to the next bit; ADD goes to the next bit.
REQ-028 SHALL go to DONE after the step for bit 0 completes.
REQ-029 SHALL make the operands for ADD equal (Qx, Qy, px_reg, py_reg).
REQ-030 SHALL abort to DONE with error = 1 when the WAIT counter reaches TIMEOUT; qx, qy and q_inf are then unspecified.
REQ-031 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-032 SHALL hold qx, qy, q_inf and error until the next accepted start.
REQ-033 SHALL ignore start while busy, with no effect on state.
REQ-034 SHALL treat k = 0 as a completion with q_inf = 1 after N+1 cycles and zero launches.
REQ-035 SHALL hold the bit index at clog2(N) bits, counting N-1 down to 0 without wrap-around.
REQ-036 SHALL keep the operand outputs stable from BIT through CAPTURE.

Reset
REQ-037 SHALL, while reset is high, force state to IDLE, busy = 0, done = 0, error = 0, q_inf = 1, qx = qy = 0, pa_reset = 1, operand outputs = 0 and counters = 0, asynchronously.
REQ-038 SHALL, on reset mid-operation, abandon the computation without producing a done pulse and hold the adder in reset through pa_reset.

Verification
REQ-039 SHALL verify the k = 0 case: start with any P gives done at cycle N+2, q_inf = 1, error = 0, and pa_reset never low.
REQ-040 SHALL verify the k = 1 case: start with P = (6eca814b...bb5b, ef4b497f...bf22) on N = 224 and p = P-224 gives qx/qy equal to P, q_inf = 0, and zero launches.
REQ-041 SHALL verify k = 3 against the real point_addition: exactly two launches, the first with operands (P, P) and the second with (2P, P), and qx/qy matching a reference 3P.
REQ-042 SHALL verify adder timeout: with a mock adder that never raises pa_result and TIMEOUT = 16, k = 2 gives done with error = 1, exactly TIMEOUT cycles after the launch enters WAIT.
REQ-043 SHALL verify reset mid-operation: reset pulsed during WAIT with k = 5 gives busy = 0, pa_reset = 1 and no done; a following start with k = 1 completes correctly.
REQ-044 SHALL verify start while busy: a second start with a different k during the computation is ignored, and the result matches the first k.
